wb_master_ctrl: RTL
===================

WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles one bus phase may wait for ack/err.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rstN  in  1  reset; asynchronous, active-low.
REQ-005 cmdValid  in  1  command offered; cmdReady  out  1  command accepted when both high.
REQ-006 cmdWrite  in  1  1 = write, 0 = read; cmdAdr  in  32  start byte address; cmdLen  in  16  word count.
REQ-007 wrValid  in  1 / wrData  in  BUS_WIDTH / wrReady  out  1  write-data stream, beat on wrValid&&wrReady.
REQ-008 rdValid  out  1 / rdData  out  BUS_WIDTH  read-data stream, no backpressure.
REQ-009 done  out  1  one-cycle end pulse; status  out  2  00 OK, 01 bus error, 10 timeout, 11 bad length.
REQ-010 cyc, stb, we  out  1; adr  out  32; sel  out  BUS_WIDTH/8; datSlvIn  out  BUS_WIDTH  (master write data).
REQ-011 datMstIn  in  BUS_WIDTH (read data); ack  in  1; err  in  1.

Function
REQ-012 States SHALL be IDLE, WAITWD, BUS, GAP, DONE.
REQ-013 IDLE: cmdReady=1, all other outputs low; on cmdValid SHALL latch cmdWrite/cmdAdr/cmdLen and leave IDLE next cycle.
REQ-014 cmdLen=0 SHALL go to DONE with status=11 and no bus activity.
REQ-015 Accepted write -> WAITWD; accepted read -> BUS.
REQ-016 WAITWD: cyc=1, stb=0, wrReady=1; on wrValid SHALL register wrData onto datSlvIn and enter BUS next cycle.
REQ-017 BUS: cyc=1, stb=1, we=latched cmdWrite, sel all ones, adr=current address; outputs SHALL stay stable until ack, err or timeout.
REQ-018 cyc SHALL remain high continuously from leaving IDLE until entering DONE.
REQ-019 On ack (err low): address += BUS_WIDTH/8 (modulo 2^32, wraps 0xFFFFFFFC->0x0), remaining count -1.
REQ-020 Read ack: datMstIn SHALL be registered to rdData with rdValid high for exactly the next cycle.
REQ-021 After non-final ack SHALL enter GAP (cyc=1, stb=0) for one cycle, then WAITWD (write) or BUS (read).
REQ-022 Final ack SHALL enter DONE with status=00.
REQ-023 err in BUS SHALL abort: DONE, status=01, no address/count update, no rdValid; err wins over simultaneous ack.
REQ-024 Wait counter SHALL clear on entering BUS and count BUS cycles without ack/err; reaching TIMEOUT SHALL abort to DONE with status=10.
REQ-025 ack/err outside BUS SHALL be ignored.
REQ-026 DONE: done=1 for one cycle, cyc=stb=0, status held until next command accepted; next cycle IDLE.
REQ-027 cmdValid outside IDLE SHALL be ignored (cmdReady=0).

Reset
REQ-028 rstN low SHALL force IDLE immediately, including mid-transfer: cyc, stb, we, done, rdValid, wrReady=0; cmdReady=0 while rstN low; adr, sel, datSlvIn, rdData, status=0; counters cleared.
REQ-029 First command SHALL be accepted no earlier than the first rising clk edge after rstN deasserts.

Verification
REQ-030 Read cmdAdr=0x100, cmdLen=3, ack one cycle after each stb -> adr 0x100,0x104,0x108; three rdValid pulses with slave data; done, status=00; cyc never drops mid-transfer.
REQ-031 Write cmdLen=2, wrValid delayed 5 cycles -> cyc=1, stb=0 during wait; two write cycles with we=1 and matching datSlvIn; status=00.
REQ-032 Read cmdLen=4, err on second word with ack also high -> abort after word 1, one rdValid, status=01, cyc low in DONE.
REQ-033 TIMEOUT=8, slave never responds -> stb held 8 cycles, then done with status=10.
REQ-034 cmdAdr=0xFFFFFFFC, cmdLen=2 -> second adr 0x00000000; cmdLen=0 -> done with status=11, cyc never asserted.
REQ-035 rstN pulled low in the middle of a write burst -> cyc/stb low asynchronously; after release, a new read command completes normally.

Source files
------------

// File: rtl/wb_master_ctrl.sv
// Purpose : Wishbone classic bus master; runs one read or write burst of cmdLen words per accepted command.
// Latency : command accepted -> first stb 1 cycle (read) or 1 cycle after the first write beat; one GAP cycle between words.
// Backpres: cmdReady only in IDLE, wrReady only while waiting for write data; the read stream has no backpressure.
//
// Ports:
//   clk, rstN                          clock, asynchronous active-low reset
//   cmdValid/cmdReady, cmdWrite,
//   cmdAdr, cmdLen                     command handshake: direction, start byte address, word count
//   wrValid/wrReady, wrData            write-data stream, one beat per bus word
//   rdValid, rdData                    read-data stream, one pulse per acknowledged read word
//   done, status                       end-of-command pulse; 00 ok, 01 bus error, 10 timeout, 11 bad length
//   cyc, stb, we, adr, sel, datSlvIn   Wishbone master outputs (datSlvIn = write data towards the slave)
//   datMstIn, ack, err                 Wishbone slave responses
module wb_master_ctrl #(
    parameter int BUS_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic                   cmdWrite,
    input  logic [31:0]            cmdAdr,
    input  logic [15:0]            cmdLen,
    input  logic                   wrValid,
    input  logic [BUS_WIDTH-1:0]   wrData,
    output logic                   wrReady,
    output logic                   rdValid,
    output logic [BUS_WIDTH-1:0]   rdData,
    output logic                   done,
    output logic [1:0]             status,
    output logic                   cyc,
    output logic                   stb,
    output logic                   we,
    output logic [31:0]            adr,
    output logic [BUS_WIDTH/8-1:0] sel,
    output logic [BUS_WIDTH-1:0]   datSlvIn,
    input  logic [BUS_WIDTH-1:0]   datMstIn,
    input  logic                   ack,
    input  logic                   err
);

    localparam int             SEL_W     = BUS_WIDTH / 8;
    localparam int             WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [31:0]    ADR_STEP  = 32'(SEL_W);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_LEN = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAITWD,
        BUS,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic              is_write;
    logic [15:0]       remaining;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            remaining <= '0;
            wait_cnt  <= '0;
            cmdReady  <= 1'b0;
            wrReady   <= 1'b0;
            rdValid   <= 1'b0;
            rdData    <= '0;
            done      <= 1'b0;
            status    <= ST_OK;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            adr       <= '0;
            sel       <= '0;
            datSlvIn  <= '0;
        end else begin
            // Pulse outputs: high for exactly the cycle after the event that sets them.
            rdValid <= 1'b0;
            rdData  <= '0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    // cmdReady comes up one edge after reset release, so no command
                    // can be taken on the release edge itself.
                    if (cmdValid && cmdReady) begin
                        is_write  <= cmdWrite;
                        adr       <= cmdAdr;
                        remaining <= cmdLen;
                        cmdReady  <= 1'b0;
                        status    <= ST_OK;
                        if (cmdLen == 16'd0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            status <= ST_BAD_LEN;
                        end else if (cmdWrite) begin
                            state   <= WAITWD;
                            cyc     <= 1'b1;
                            wrReady <= 1'b1;
                        end else begin
                            state    <= BUS;
                            cyc      <= 1'b1;
                            stb      <= 1'b1;
                            we       <= 1'b0;
                            sel      <= '1;
                            wait_cnt <= '0;
                        end
                    end else begin
                        cmdReady <= 1'b1;
                    end
                end

                WAITWD: begin
                    // cyc stays asserted while the producer is slow, holding the bus.
                    if (wrValid) begin
                        datSlvIn <= wrData;
                        wrReady  <= 1'b0;
                        state    <= BUS;
                        stb      <= 1'b1;
                        we       <= 1'b1;
                        sel      <= '1;
                        wait_cnt <= '0;
                    end
                end

                BUS: begin
                    if (err) begin
                        // err beats a simultaneous ack: no address/count step, no read data.
                        state  <= DONE;
                        done   <= 1'b1;
                        status <= ST_BUS_ERR;
                        cyc    <= 1'b0;
                        stb    <= 1'b0;
                        we     <= 1'b0;
                        sel    <= '0;
                    end else if (ack) begin
                        adr       <= adr + ADR_STEP;
                        remaining <= remaining - 16'd1;
                        stb       <= 1'b0;
                        we        <= 1'b0;
                        sel       <= '0;
                        if (!is_write) begin
                            rdValid <= 1'b1;
                            rdData  <= datMstIn;
                        end
                        if (remaining == 16'd1) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            status <= ST_OK;
                            cyc    <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This is the TIMEOUT-th cycle with stb high and no response.
                        state  <= DONE;
                        done   <= 1'b1;
                        status <= ST_TIMEOUT;
                        cyc    <= 1'b0;
                        stb    <= 1'b0;
                        we     <= 1'b0;
                        sel    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (is_write) begin
                        state   <= WAITWD;
                        wrReady <= 1'b1;
                    end else begin
                        state    <= BUS;
                        stb      <= 1'b1;
                        sel      <= '1;
                        wait_cnt <= '0;
                    end
                end

                DONE: begin
                    // adr/datSlvIn stay visible through DONE, then return to zero in IDLE.
                    state    <= IDLE;
                    cmdReady <= 1'b1;
                    adr      <= '0;
                    datSlvIn <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
